// File: rtl/gpio_multi_adder.sv
// Multi-channel add/sub/accumulate peripheral with a result FIFO and valid/ready output.
// Optional build macro GPIO_MULTI_ADDER_SATURATE_EN clamps results instead of wrapping.
module gpio_multi_adder #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 2,
    parameter int DEPTH    = 4,
    localparam int CW      = (CHANNELS > 1) ? $clog2(CHANNELS) : 1,
    localparam int LW      = $clog2(DEPTH) + 1
) (
    input  logic                clock,
    input  logic                resetb,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CW-1:0]       in_chan,
    input  logic [1:0]          in_mode,
    input  logic [WIDTH-1:0]    in_a,
    input  logic [WIDTH-1:0]    in_b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    out_data,
    output logic                out_carry,
    output logic [CW-1:0]       out_chan,
    output logic [CHANNELS-1:0] ovf_flags,
    output logic [LW-1:0]       fifo_level
);
    localparam int AW = $clog2(DEPTH);
    localparam int EW = WIDTH + 1 + CW;
    localparam logic [CW:0]   CH_LIM = (CW + 1)'(CHANNELS);
    localparam logic [LW-1:0] FULL   = LW'(DEPTH);

    localparam logic [1:0] MODE_ADD = 2'b00;
    localparam logic [1:0] MODE_SUB = 2'b01;
    localparam logic [1:0] MODE_ACC = 2'b10;
    localparam logic [1:0] MODE_CLR = 2'b11;

    logic                push, pop, chan_ok;
    logic [CHANNELS-1:0] hit;
    logic [WIDTH-1:0]    acc_cur, sub_diff, res_data;
    logic [WIDTH:0]      add_sum, acc_sum;
    logic                borrow, res_carry;
    logic [WIDTH-1:0]    acc [CHANNELS];
    logic [EW-1:0]       mem [DEPTH];
    logic [EW-1:0]       head;
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [LW-1:0]       level;

    // No full-bypass: a pop in the same cycle does not open the input.
    assign in_ready   = (level != FULL);
    assign push       = in_valid && in_ready;
    assign out_valid  = (level != '0);
    assign pop        = out_valid && out_ready;
    assign fifo_level = level;
    assign chan_ok    = ({1'b0, in_chan} < CH_LIM);

    always_comb begin
        hit     = '0;
        acc_cur = '0;
        if (chan_ok) begin
            hit = CHANNELS'(1) << in_chan;
        end
        for (int i = 0; i < CHANNELS; i++) begin
            if (hit[i]) begin
                acc_cur = acc[i];
            end
        end
    end

    assign add_sum  = {1'b0, in_a} + {1'b0, in_b};
    assign acc_sum  = {1'b0, acc_cur} + {1'b0, in_a};
    assign sub_diff = in_a - in_b;
    assign borrow   = (in_a < in_b);

    always_comb begin
        res_data  = '0;
        res_carry = 1'b0;
        case (in_mode)
            MODE_ADD: begin
                res_carry = add_sum[WIDTH];
                res_data  = add_sum[WIDTH-1:0];
            end
            MODE_SUB: begin
                res_carry = borrow;
                res_data  = sub_diff;
            end
            MODE_ACC: begin
                if (chan_ok) begin
                    res_carry = acc_sum[WIDTH];
                    res_data  = acc_sum[WIDTH-1:0];
                end
            end
            default: ;
        endcase
`ifdef GPIO_MULTI_ADDER_SATURATE_EN
        if (res_carry) begin
            res_data = (in_mode == MODE_SUB) ? '0 : '1;
        end
`endif
    end

    // Accumulator stores the same value that is pushed, so saturation carries over.
    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            for (int i = 0; i < CHANNELS; i++) begin
                acc[i] <= '0;
            end
            ovf_flags <= '0;
        end else if (push) begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (hit[i]) begin
                    if (in_mode == MODE_ACC) begin
                        acc[i] <= res_data;
                    end else if (in_mode == MODE_CLR) begin
                        acc[i]       <= '0;
                        ovf_flags[i] <= 1'b0;
                    end
                    if (res_carry) begin
                        ovf_flags[i] <= 1'b1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {res_carry, in_chan, res_data};
        end
    end

    always_ff @(posedge clock or negedge resetb) begin
        if (!resetb) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: ;
            endcase
        end
    end

    assign head      = mem[rd_ptr];
    assign out_data  = out_valid ? head[WIDTH-1:0] : '0;
    assign out_chan  = out_valid ? head[WIDTH+CW-1:WIDTH] : '0;
    assign out_carry = out_valid & head[EW-1];

endmodule

// File: tb/tb_gpio_multi_adder.sv
// Bench for gpio_multi_adder: directed scenarios with literal expectations plus
// randomized traffic compared every cycle against a queue/array reference model.
module tb_gpio_multi_adder;
    localparam int WIDTH    = 8;
    localparam int CHANNELS = 2;
    localparam int DEPTH    = 4;
    localparam int CW       = 1;
    localparam int LW       = 3;
`ifdef GPIO_MULTI_ADDER_SATURATE_EN
    localparam bit SAT      = 1'b1;
    localparam int EXP_ADD  = 'hFF;
    localparam int EXP_SUB  = 'h00;
`else
    localparam bit SAT      = 1'b0;
    localparam int EXP_ADD  = 'h10;
    localparam int EXP_SUB  = 'hFE;
`endif

    logic                clock, resetb;
    logic                in_valid, in_ready;
    logic [CW-1:0]       in_chan;
    logic [1:0]          in_mode;
    logic [WIDTH-1:0]    in_a, in_b;
    logic                out_valid, out_ready;
    logic [WIDTH-1:0]    out_data;
    logic                out_carry;
    logic [CW-1:0]       out_chan;
    logic [CHANNELS-1:0] ovf_flags;
    logic [LW-1:0]       fifo_level;

    gpio_multi_adder #(.WIDTH(WIDTH), .CHANNELS(CHANNELS), .DEPTH(DEPTH)) dut (
        .clock(clock), .resetb(resetb),
        .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_mode(in_mode),
        .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_carry(out_carry), .out_chan(out_chan),
        .ovf_flags(ovf_flags), .fifo_level(fifo_level)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        int data;
        bit carry;
        int chan;
    } ent_t;

    ent_t                q[$];
    int                  macc [CHANNELS];
    bit [CHANNELS-1:0]   mflags;
    int                  checks = 0;
    int                  passes = 0;

    task automatic check(input string name, input longint act, input longint exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    function automatic void model_reset();
        q.delete();
        for (int i = 0; i < CHANNELS; i++) macc[i] = 0;
        mflags = '0;
    endfunction

    // Arithmetic straight from the mode definitions, using plain integers.
    function automatic void model_req(input int ch, input int mode, input int a, input int b);
        int  lim = 1 << WIDTH;
        bit  ok  = (ch < CHANNELS);
        int  d   = 0;
        bit  c   = 1'b0;
        ent_t e;
        case (mode)
            0: begin
                d = a + b;
                c = (d >= lim);
                if (c) d = SAT ? lim - 1 : d - lim;
            end
            1: begin
                c = (a < b);
                if (c) d = SAT ? 0 : a - b + lim;
                else   d = a - b;
            end
            2: if (ok) begin
                d = macc[ch] + a;
                c = (d >= lim);
                if (c) d = SAT ? lim - 1 : d - lim;
                macc[ch] = d;
            end
            default: if (ok) begin
                macc[ch]   = 0;
                mflags[ch] = 1'b0;
            end
        endcase
        if (ok && c) mflags[ch] = 1'b1;
        e.data = d; e.carry = c; e.chan = ch;
        q.push_back(e);
    endfunction

    task automatic compare();
        check("out_valid", out_valid, q.size() != 0);
        check("fifo_level", fifo_level, q.size());
        check("in_ready", in_ready, q.size() != DEPTH);
        check("ovf_flags", ovf_flags, mflags);
        if (q.size() != 0) begin
            check("out_data", out_data, q[0].data);
            check("out_carry", out_carry, q[0].carry);
            check("out_chan", out_chan, q[0].chan);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, advance the model, compare at the next falling edge.
    task automatic step(input bit v, input int ch, input int mode, input int a, input int b, input bit ordy);
        bit acc_m, pop_m;
        in_valid  = v;
        in_chan   = ch[CW-1:0];
        in_mode   = mode[1:0];
        in_a      = a[WIDTH-1:0];
        in_b      = b[WIDTH-1:0];
        out_ready = ordy;
        acc_m = v && (q.size() != DEPTH);
        pop_m = ordy && (q.size() != 0);
        @(posedge clock);
        if (pop_m) void'(q.pop_front());
        if (acc_m) model_req(ch, mode, a, b);
        @(negedge clock);
        compare();
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) step(1'b0, 0, 0, 0, 0, 1'b1);
    endtask

    initial begin
        resetb = 1'b0; in_valid = 1'b0; in_chan = '0; in_mode = '0;
        in_a = '0; in_b = '0; out_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        compare();
        check("rst_out_valid", out_valid, 0);
        check("rst_level", fifo_level, 0);
        check("rst_in_ready", in_ready, 1);
        check("rst_ovf", ovf_flags, 0);

        step(1'b1, 0, 0, 'hF0, 'h20, 1'b1);
        check("lit_add_data", out_data, EXP_ADD);
        check("lit_add_carry", out_carry, 1);
        check("lit_add_ovf", ovf_flags, 2'b01);

        step(1'b1, 1, 1, 'h05, 'h07, 1'b1);
        check("lit_sub_data", out_data, EXP_SUB);
        check("lit_sub_carry", out_carry, 1);

        step(1'b1, 1, 3, 0, 0, 1'b1);
        check("lit_clr_ovf1", ovf_flags[1], 0);
        step(1'b1, 1, 2, 'h40, 0, 1'b1);
        check("lit_acc1", out_data, 'h40);
        step(1'b1, 1, 2, 'h40, 0, 1'b1);
        check("lit_acc2", out_data, 'h80);
        step(1'b1, 1, 2, 'h40, 0, 1'b1);
        check("lit_acc3", out_data, 'hC0);
        check("lit_acc_ovf1", ovf_flags[1], 0);
        step(1'b1, 1, 3, 0, 0, 1'b1);
        check("lit_clr_data", out_data, 'h00);
        drain();

        for (int i = 1; i <= 4; i++) step(1'b1, 0, 0, i, 1, 1'b0);
        check("lit_full_ready", in_ready, 0);
        check("lit_full_level", fifo_level, 4);
        step(1'b1, 0, 0, 9, 9, 1'b0);
        check("lit_held_level", fifo_level, 4);
        step(1'b1, 0, 0, 9, 9, 1'b1);
        check("lit_nobypass_level", fifo_level, 3);
        step(1'b1, 0, 0, 9, 9, 1'b1);
        check("lit_fifth_level", fifo_level, 3);
        check("lit_order_head", out_data, 'h04);
        drain();

        step(1'b1, 0, 3, 0, 0, 1'b0);
        step(1'b1, 0, 2, 'h33, 0, 1'b0);
        step(1'b1, 1, 0, 1, 1, 1'b0);
        check("lit_pre_rst_level", fifo_level, 3);
        in_valid = 1'b0;
        resetb = 1'b0;
        #1;
        check("lit_mid_rst_valid", out_valid, 0);
        check("lit_mid_rst_level", fifo_level, 0);
        check("lit_mid_rst_data", out_data, 0);
        model_reset();
        @(negedge clock);
        resetb = 1'b1;
        @(negedge clock);
        compare();
        step(1'b1, 0, 2, 'h01, 0, 1'b1);
        check("lit_post_rst_acc", out_data, 'h01);

        for (int n = 0; n < 3000; n++) begin
            int  a, b, mode;
            bit  ordy;
            a    = ($urandom_range(0, 3) == 0) ? 'hFF - $urandom_range(0, 3) : $urandom_range(0, 255);
            b    = $urandom_range(0, 255);
            mode = ($urandom_range(0, 2) == 0) ? 2 : $urandom_range(0, 3);
            ordy = ((n / 200) % 2 == 0) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            step($urandom_range(0, 3) != 0, $urandom_range(0, (1 << CW) - 1), mode, a, b, ordy);
        end
        drain();

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule

// File: doc/gpio_multi_adder.md
Name: gpio_multi_adder

Overview:
- Parametrised multi-channel arithmetic peripheral for the user project area. It is the successor to the single-channel add peripheral driven from mprj_io.
- Accepts operand pairs tagged with a channel number and operation mode.
- Computes add, subtract, or per-channel accumulate.
- Queues results in an output FIFO with a valid/ready handshake toward the pad-side serialiser.

Parameters:
- WIDTH, 8, operand/result width in bits (2..32).
- CHANNELS, 2, number of independent accumulator channels (1..8).
- DEPTH, 4, result FIFO depth; power of two, 2..16.

Ports:
- clock  input  1  system clock, all logic on rising edge.
- resetb  input  1  asynchronous active-low reset.
- in_valid  input  1  operand request valid.
- in_ready  output  1  request accepted when in_valid && in_ready.
- in_chan  input  max(1,$clog2(CHANNELS))  target channel.
- in_mode  input  2  00 add a+b, 01 sub a-b, 10 accumulate acc+=a, 11 clear channel.
- in_a  input  WIDTH  operand A.
- in_b  input  WIDTH  operand B (ignored in modes 10/11).
- out_valid  output  1  FIFO head valid.
- out_ready  input  1  consumer pops head when out_valid && out_ready.
- out_data  output  WIDTH  result at FIFO head.
- out_carry  output  1  carry (add/acc) or borrow (sub) of the head entry.
- out_chan  output  max(1,$clog2(CHANNELS))  channel tag of the head entry.
- ovf_flags  output  CHANNELS  sticky per-channel overflow flags.
- fifo_level  output  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, resetb=0):
  - All accumulators, ovf_flags, FIFO pointers and occupancy go to 0.
  - out_valid=0, out_data=0, out_carry=0, out_chan=0, fifo_level=0.
  - in_ready=1 one cycle after reset deasserts.
- Reset mid-operation discards FIFO contents and accumulator state with no partial output.
- in_ready = (fifo_level != DEPTH). There is no full-bypass: when the FIFO is full, in_ready=0 even if out_ready=1 in the same cycle.
- Accept cycle N: the result is written to the FIFO at the edge ending cycle N. If the FIFO was empty, out_valid=1 in cycle N+1 (latency 1).
- Add: {carry,data} = a + b computed at WIDTH+1 bits.
- Sub: data = a - b mod 2^WIDTH; carry=1 when a<b (borrow).
- Accumulate: acc[chan] <= acc[chan] + a; the result pushed is the new acc value; carry = bit WIDTH of the sum.
- Clear: acc[chan] <= 0 and ovf_flags[chan] <= 0. Pushes data=0, carry=0 so every accepted request yields exactly one result.
- ovf_flags[chan] sets on any accepted request on that channel with carry=1. It stays set until a clear on that channel or reset.
- in_chan >= CHANNELS:
  - Request is accepted.
  - Add/sub results are pushed normally.
  - Accumulate/clear push data=0, carry=0 and change no state.
- Simultaneous push and pop: occupancy unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- out_data/out_carry/out_chan hold stable while out_valid && !out_ready.
- Pop on empty is ignored (out_ready with out_valid=0 has no effect).
- Back-to-back accumulate on the same channel in consecutive cycles uses the updated value; no hazard stalls.

Optional Feature:
- Macro: GPIO_MULTI_ADDER_SATURATE_EN.
- Defined:
  - Add and accumulate clamp to 2^WIDTH-1 on carry.
  - Sub clamps to 0 on borrow.
  - The accumulator stores the clamped value.
  - out_carry and ovf_flags still report the overflow event.
- Undefined: all arithmetic wraps modulo 2^WIDTH as described above.

Test Plan:
- Reset then idle, WIDTH=8: out_valid=0, fifo_level=0, in_ready=1, ovf_flags=0.
- Add a=8'hF0 b=8'h20 chan 0, out_ready=1:
  - Wrap build: out_valid next cycle, out_data=8'h10, out_carry=1, ovf_flags=2'b01.
  - Saturate build: out_data=8'hFF.
- Sub a=8'h05 b=8'h07 chan 1:
  - Wrap build: out_data=8'hFE, out_carry=1.
  - Saturate build: out_data=8'h00.
- Accumulate chan 1 with a=8'h40 three times back-to-back, then clear chan 1:
  - Results 8'h40, 8'h80, 8'hC0, then 8'h00.
  - ovf_flags[1]=0 throughout.
- out_ready=0, push 5 requests with DEPTH=4:
  - in_ready drops after the 4th; fifo_level=4; 5th held.
  - Raise out_ready: results pop in order, 5th accepted after the first pop.
- Assert resetb=0 with 3 entries queued and acc[0]=8'h33: out_valid=0 immediately; after release, accumulate a=8'h01 on chan 0 returns 8'h01.
